// File: rtl/mips_avalon_pkg.sv
// Shared types and constants for the MIPS Avalon-MM RAM slave.
package mips_avalon_pkg;

  localparam int unsigned BYTE_ADDR_SHIFT = 2;

  typedef enum logic [1:0] {
    RespOkay        = 2'b00,
    RespSlaveError  = 2'b10,
    RespDecodeError = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck
  } ram_state_t;

endpackage

// File: rtl/mips_avalon_ram_slave_if.sv
// Avalon-MM bus bundle between the MIPS CPU (master) and the RAM slave.
interface mips_avalon_ram_slave_if;

  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [1:0]  response;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, response
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, response
  );

endinterface

// File: rtl/mips_avalon_lfsr.sv
// 16-bit Galois LFSR (taps 16,14,13,11) used to randomise RAM wait states.
module mips_avalon_lfsr #(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        advance_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance_i) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/mips_avalon_ram_slave.sv
// Avalon-MM slave RAM for the MIPS CPU bus with fixed wait states and error responses.
// Define MIPS_AVALON_RAND_WAIT_EN to add LFSR-driven random extra wait cycles.
module mips_avalon_ram_slave
  import mips_avalon_pkg::*;
#(
  parameter logic [31:0] ADDR_START     = 32'hBFC00000,
  parameter int unsigned MEM_WORDS      = 1024,
  parameter int unsigned READ_DELAY     = 2,
  parameter int unsigned WRITE_DELAY    = 2,
  parameter string       RAM_INIT_FILE  = "",
  parameter int unsigned RAND_MAX_EXTRA = 3,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input logic                    clk,
  input logic                    rst,
  mips_avalon_ram_slave_if.slave bus
);

  localparam int unsigned IdxW     = $clog2(MEM_WORDS);
  localparam int unsigned MaxDelay =
      ((READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY) + RAND_MAX_EXTRA;
  localparam int unsigned CtrW     = $clog2(MaxDelay + 1);

  if (MEM_WORDS < 1024) begin : g_chk_words
    $error("MEM_WORDS must be at least 1024");
  end
  if ((MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_chk_pow2
    $error("MEM_WORDS must be a power of two");
  end
  if (READ_DELAY < 1) begin : g_chk_rd
    $error("READ_DELAY must be at least 1");
  end
  if (WRITE_DELAY < 1) begin : g_chk_wr
    $error("WRITE_DELAY must be at least 1");
  end
  if (ADDR_START[1:0] != 2'b00) begin : g_chk_align
    $error("ADDR_START must be 4-byte aligned");
  end
  if (LFSR_SEED == 16'h0000) begin : g_chk_seed
    $error("LFSR_SEED must be non-zero");
  end

  logic [31:0] mem [MEM_WORDS];

  // Power-up image; contents are never touched by reset.
  initial begin
    for (int unsigned i = 0; i < MEM_WORDS; i++) mem[i] = '0;
  end

  ram_state_t      state_q, state_d;
  logic [CtrW-1:0] ctr_q, ctr_d;
  logic [31:0]     readdata_q, readdata_d;
  resp_t           response_q, response_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            op_wr_q, op_wr_d;

  logic            req;
  logic [31:0]     offset;
  logic            in_range;
  logic [IdxW-1:0] idx;
  logic [CtrW-1:0] extra;
  logic [CtrW-1:0] delay;

  assign req      = bus.read | bus.write;
  assign offset   = bus.address - ADDR_START;
  assign in_range = (bus.address >= ADDR_START) && ((offset >> BYTE_ADDR_SHIFT) < MEM_WORDS);
  assign idx      = offset[BYTE_ADDR_SHIFT +: IdxW];

`ifdef MIPS_AVALON_RAND_WAIT_EN
  logic [15:0] lfsr_state;
  logic        accept;

  assign accept = (state_q == StIdle) && req;

  mips_avalon_lfsr #(
    .Seed(LFSR_SEED)
  ) u_lfsr (
    .clk_i    (clk),
    .rst_ni   (rst),
    .advance_i(accept),
    .state_o  (lfsr_state)
  );

  assign extra = CtrW'(32'(lfsr_state) % (RAND_MAX_EXTRA + 1));
`else
  assign extra = '0;
`endif

  assign delay = (bus.write ? CtrW'(WRITE_DELAY) : CtrW'(READ_DELAY)) + extra;

  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    readdata_d = readdata_q;
    response_d = response_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    op_wr_d    = op_wr_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (!in_range) begin
            state_d    = StAck;
            response_d = RespDecodeError;
            op_wr_d    = 1'b0;
          end else if ((bus.address[1:0] != 2'b00) || (bus.read && bus.write)) begin
            state_d    = StAck;
            response_d = RespSlaveError;
            op_wr_d    = 1'b0;
          end else begin
            idx_d   = idx;
            wdata_d = bus.writedata;
            be_d    = bus.byteenable;
            op_wr_d = bus.write;
            ctr_d   = delay - CtrW'(1);
            if (delay == CtrW'(1)) begin
              state_d    = StAck;
              response_d = RespOkay;
              if (!bus.write) readdata_d = mem[idx];
            end else begin
              state_d = StWait;
            end
          end
        end
      end
      StWait: begin
        // Master withdrew the request: drop it silently, outputs keep old values.
        if (!req) begin
          state_d = StIdle;
        end else begin
          ctr_d = ctr_q - CtrW'(1);
          if (ctr_q == CtrW'(1)) begin
            state_d    = StAck;
            response_d = RespOkay;
            if (!op_wr_q) readdata_d = mem[idx_q];
          end
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ctr_q      <= '0;
      readdata_q <= '0;
      response_q <= RespOkay;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      op_wr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      readdata_q <= readdata_d;
      response_q <= response_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      op_wr_q    <= op_wr_d;
    end
  end

  // Single write port: writes commit only in the completion cycle.
  always_ff @(posedge clk) begin
    if ((state_q == StAck) && op_wr_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign bus.waitrequest = req && (state_q != StAck);
  assign bus.readdata    = readdata_q;
  assign bus.response    = response_q;

endmodule

// File: tb/tb_mips_avalon_ram_slave.sv
// Randomised self-checking bench for mips_avalon_ram_slave against a word-array model.
module tb_mips_avalon_ram_slave;

  localparam logic [31:0] Start = 32'hBFC00000;
  localparam int unsigned Words = 1024;
  localparam int          RdDly = 3;
  localparam int          WrDly = 2;
  localparam int          Extra = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mips_avalon_ram_slave_if bus ();

  mips_avalon_ram_slave #(
    .ADDR_START    (Start),
    .MEM_WORDS     (Words),
    .READ_DELAY    (RdDly),
    .WRITE_DELAY   (WrDly),
    .RAM_INIT_FILE (""),
    .RAND_MAX_EXTRA(Extra),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Master must hold a stalled request stable unless it withdraws it.
  assert property (@(posedge clk) disable iff (!rst)
    bus.waitrequest |=> (!(bus.read || bus.write)) ||
      ($stable(bus.address) && $stable(bus.writedata) && $stable(bus.byteenable) &&
       $stable(bus.read) && $stable(bus.write)));

  logic [31:0] model_mem [Words];
  logic [31:0] exp_rdata;
  int total = 0;
  int bad   = 0;

  function automatic logic [1:0] exp_resp(input logic rd, input logic wr, input logic [31:0] a);
    longint unsigned la = 64'(a);
    if (la < 64'(Start) || la >= 64'(Start) + 4 * 64'(Words)) return 2'b11;
    if ((a % 4) != 0 || (rd && wr)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - Start) / 4);
  endfunction

  function automatic bit wait_ok(input int got, input int base, input bit exact);
`ifdef MIPS_AVALON_RAND_WAIT_EN
    if (!exact) return (got >= base) && (got <= base + Extra);
`endif
    return got == base;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    int i = word_of(a);
    for (int b = 0; b < 4; b++) if (be[b]) model_mem[i][8*b +: 8] = wd[8*b +: 8];
  endtask

  // Called at posedge+1; returns at posedge+1 with request released.
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int abort_after, output int waits,
                      output logic [31:0] rdata, output logic [1:0] resp, output bit done);
    bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = wd; bus.byteenable = be;
    waits = 0; done = 1'b0; rdata = 'x; resp = 'x;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (!bus.waitrequest) begin
        done = 1'b1; rdata = bus.readdata; resp = bus.response;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
      if (done || (abort_after != 0 && waits == abort_after)) break;
    end
    bus.read = 1'b0; bus.write = 1'b0;
  endtask

  task automatic test_reset();
    bus.read = 0; bus.write = 0; bus.address = 0; bus.writedata = 0; bus.byteenable = 0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    total++; if (bus.waitrequest !== 1'b0) begin bad++; $display("FAIL reset_wait: got %b want 0", bus.waitrequest); end
    total++; if (bus.readdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", bus.readdata); end
    total++; if (bus.response !== 2'b00) begin bad++; $display("FAIL reset_resp: got %b want 00", bus.response); end
    @(posedge clk); #1;
    exp_rdata = 32'h0;
  endtask

  task automatic test_byte_merge();
    int w; logic [31:0] d; logic [1:0] r; bit done;
    xfer(0, 1, Start, 32'hDEADBEEF, 4'hF, 0, w, d, r, done);
    model_write(Start, 32'hDEADBEEF, 4'hF);
    total++; if (!done || !wait_ok(w, WrDly, 0)) begin bad++; $display("FAIL merge_wr_wait: got %0d done=%0b want %0d", w, done, WrDly); end
    xfer(0, 1, Start, 32'h000000AA, 4'h1, 0, w, d, r, done);
    model_write(Start, 32'h000000AA, 4'h1);
    total++; if (r !== 2'b00) begin bad++; $display("FAIL merge_wr_resp: got %b want 00", r); end
    xfer(1, 0, Start, 32'h0, 4'h0, 0, w, d, r, done);
    exp_rdata = 32'hDEADBEAA;
    total++; if (d !== 32'hDEADBEAA) begin bad++; $display("FAIL merge_rd: got %h want deadbeaa", d); end
    total++; if (r !== 2'b00) begin bad++; $display("FAIL merge_rd_resp: got %b want 00", r); end
  endtask

  task automatic test_read_delay();
    int w; logic [31:0] d; logic [1:0] r; bit done;
    xfer(1, 0, Start + 32'd4, 32'h0, 4'h0, 0, w, d, r, done);
    exp_rdata = model_mem[1];
    total++; if (!done || !wait_ok(w, RdDly, 0)) begin bad++; $display("FAIL rd_delay_wait: got %0d want %0d", w, RdDly); end
    total++; if (d !== exp_rdata) begin bad++; $display("FAIL rd_delay_data: got %h want %h", d, exp_rdata); end
  endtask

  task automatic test_decode_error();
    int w; logic [31:0] d; logic [1:0] r; bit done;
    xfer(1, 0, 32'h0, 32'h0, 4'h0, 0, w, d, r, done);
    total++; if (!done || w != 1) begin bad++; $display("FAIL decode_wait: got %0d want 1", w); end
    total++; if (r !== 2'b11) begin bad++; $display("FAIL decode_resp: got %b want 11", r); end
    total++; if (d !== exp_rdata) begin bad++; $display("FAIL decode_rdata: got %h want %h", d, exp_rdata); end
  endtask

  task automatic test_misaligned();
    int w; logic [31:0] d; logic [1:0] r; bit done;
    xfer(0, 1, Start + 32'd2, 32'h55555555, 4'hF, 0, w, d, r, done);
    total++; if (r !== 2'b10 || w != 1) begin bad++; $display("FAIL misalign_resp: got %b/%0d want 10/1", r, w); end
    xfer(1, 0, Start, 32'h0, 4'h0, 0, w, d, r, done);
    exp_rdata = model_mem[0];
    total++; if (d !== exp_rdata) begin bad++; $display("FAIL misalign_mem: got %h want %h", d, exp_rdata); end
  endtask

  task automatic test_rw_both();
    int w; logic [31:0] d; logic [1:0] r; bit done;
    xfer(1, 1, Start + 32'd20, 32'h12345678, 4'hF, 0, w, d, r, done);
    total++; if (r !== 2'b10) begin bad++; $display("FAIL rw_both_resp: got %b want 10", r); end
    xfer(1, 0, Start + 32'd20, 32'h0, 4'h0, 0, w, d, r, done);
    exp_rdata = model_mem[5];
    total++; if (d !== exp_rdata) begin bad++; $display("FAIL rw_both_mem: got %h want %h", d, exp_rdata); end
  endtask

  task automatic test_abort();
    int w; logic [31:0] d; logic [1:0] r; bit done;
    logic [31:0] v = $urandom;
    xfer(0, 1, Start + 32'd8, v, 4'hF, 0, w, d, r, done);
    model_write(Start + 32'd8, v, 4'hF);
    xfer(1, 0, Start + 32'd12, 32'h0, 4'h0, 1, w, d, r, done);
    total++; if (done) begin bad++; $display("FAIL abort_done: got 1 want 0"); end
    @(posedge clk); #1;
    total++; if (bus.readdata !== exp_rdata || bus.response !== 2'b00) begin
      bad++; $display("FAIL abort_hold: got %h/%b want %h/00", bus.readdata, bus.response, exp_rdata);
    end
    xfer(1, 0, Start + 32'd8, 32'h0, 4'h0, 0, w, d, r, done);
    exp_rdata = model_mem[2];
    total++; if (!done || !wait_ok(w, RdDly, 0)) begin bad++; $display("FAIL abort_restart_wait: got %0d want %0d", w, RdDly); end
    total++; if (d !== exp_rdata || r !== 2'b00) begin bad++; $display("FAIL abort_restart_data: got %h/%b want %h/00", d, r, exp_rdata); end
  endtask

  task automatic test_reset_mid_write();
    int w; logic [31:0] d; logic [1:0] r; bit done;
    xfer(0, 1, Start + 32'h10, 32'h11223344, 4'hF, 0, w, d, r, done);
    model_write(Start + 32'h10, 32'h11223344, 4'hF);
    xfer(1, 0, Start + 32'h10, 32'h0, 4'h0, 0, w, d, r, done);
    xfer(1, 0, 32'h0, 32'h0, 4'h0, 0, w, d, r, done);
    bus.write = 1'b1; bus.address = Start + 32'h10; bus.writedata = 32'hCAFEF00D; bus.byteenable = 4'hF;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0; bus.write = 1'b0;
    #1;
    total++; if (bus.waitrequest !== 1'b0) begin bad++; $display("FAIL rst_mid_wait: got %b want 0", bus.waitrequest); end
    total++; if (bus.readdata !== 32'h0 || bus.response !== 2'b00) begin
      bad++; $display("FAIL rst_mid_out: got %h/%b want 0/00", bus.readdata, bus.response);
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    exp_rdata = 32'h0;
    xfer(1, 0, Start + 32'h10, 32'h0, 4'h0, 0, w, d, r, done);
    exp_rdata = model_mem[4];
    total++; if (d !== 32'h11223344 || r !== 2'b00) begin bad++; $display("FAIL rst_mid_mem: got %h/%b want 11223344/00", d, r); end
  endtask

  task automatic test_random(input int n);
    int w; logic [31:0] d; logic [1:0] r; bit done;
    logic rd, wr; logic [31:0] a, wd; logic [3:0] be; logic [1:0] er; int ew;
    for (int k = 0; k < n; k++) begin
      int cat = int'($urandom_range(0, 9));
      wr = 1'($urandom_range(0, 1)); rd = !wr;
      wd = $urandom; be = 4'($urandom_range(0, 15));
      case (cat)
        0: a = Start - 32'(4 * $urandom_range(1, 64));
        1: a = Start + 32'(4 * Words) + 32'(4 * $urandom_range(0, 64));
        2: a = Start + 32'(4 * $urandom_range(0, Words - 1)) + 32'($urandom_range(1, 3));
        3: a = Start + 32'(4 * (Words - 1));
        4: begin a = Start + 32'(4 * $urandom_range(0, 7)); rd = 1'b1; wr = 1'b1; end
        default: a = Start + 32'(4 * $urandom_range(0, (k % 3 == 0) ? Words - 1 : 7));
      endcase
      xfer(rd, wr, a, wd, be, 0, w, d, r, done);
      er = exp_resp(rd, wr, a);
      ew = (er != 2'b00) ? 1 : (wr ? WrDly : RdDly);
      if (er == 2'b00 && wr) model_write(a, wd, be);
      if (er == 2'b00 && !wr) exp_rdata = model_mem[word_of(a)];
      total++; if (!done) begin bad++; $display("FAIL rand_timeout: addr %h no completion", a); end
      total++; if (r !== er) begin bad++; $display("FAIL rand_resp: addr %h got %b want %b", a, r, er); end
      total++; if (!wait_ok(w, ew, er != 2'b00)) begin bad++; $display("FAIL rand_wait: addr %h got %0d want %0d", a, w, ew); end
      total++; if (d !== exp_rdata) begin bad++; $display("FAIL rand_rdata: addr %h got %h want %h", a, d, exp_rdata); end
    end
  endtask

`ifdef MIPS_AVALON_RAND_WAIT_EN
  task automatic test_rand_wait();
    int w; logic [31:0] d; logic [1:0] r; bit done; logic [31:0] a;
    bit seen [Extra + 1];
    for (int k = 0; k < 1000; k++) begin
      a = Start + 32'(4 * $urandom_range(0, Words - 1));
      xfer(1, 0, a, 32'h0, 4'h0, 0, w, d, r, done);
      exp_rdata = model_mem[word_of(a)];
      total++;
      if (!done || w < RdDly || w > RdDly + Extra) begin
        bad++; $display("FAIL rwait_range: got %0d want %0d..%0d", w, RdDly, RdDly + Extra);
      end else begin
        seen[w - RdDly] = 1'b1;
      end
      total++; if (d !== exp_rdata) begin bad++; $display("FAIL rwait_data: got %h want %h", d, exp_rdata); end
    end
    for (int e = 0; e <= Extra; e++) begin
      total++; if (!seen[e]) begin bad++; $display("FAIL rwait_cover: extra %0d seen 0 want 1", e); end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < int'(Words); i++) model_mem[i] = 32'h0;
    exp_rdata = 32'h0;
    test_reset();
    test_byte_merge();
    test_read_delay();
    test_decode_error();
    test_misaligned();
    test_rw_both();
    test_abort();
    test_reset_mid_write();
    test_random(300);
`ifdef MIPS_AVALON_RAND_WAIT_EN
    test_rand_wait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
